// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and helpers for the truth-table sweeper: FSM state encoding,
// row count and the row-to-signature-bit mapping.
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } sweep_state_e;

  localparam int ROWS = 8;

  // Row 0 lands in the MSB of the signature, row 7 in the LSB.
  function automatic logic [2:0] sig_bit(input logic [2:0] row);
    return 3'd7 - row;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Handshake/result bundle between the sweeper (slave) and the environment that
// starts it and hosts the combinational circuit being characterised (master).
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic [2:0] in_vec;
  logic       dut_out;
  logic       busy;
  logic       done;
  logic [7:0] signature;
  logic       pass;
  logic [3:0] mismatch_count;
  logic [2:0] fail_row;
  logic       unstable;

  modport slave (
    input  start, abort, dut_out,
    output in_vec, busy, done, signature, pass, mismatch_count, fail_row, unstable
  );

  modport master (
    output start, abort, dut_out,
    input  in_vec, busy, done, signature, pass, mismatch_count, fail_row, unstable
  );
endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// Per-row settle counter: runs 0..SETTLE_CYCLES-1 while enabled and flags the
// last and second-to-last cycle of the row.
module sweep_settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last,
  output logic prelast
);

  localparam int CW = ($clog2(SETTLE_CYCLES) < 1) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [CW-1:0] LAST_V = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] PRE_V  = CW'(SETTLE_CYCLES - 2);
  localparam logic [CW-1:0] ONE_V  = CW'(1);

  logic [CW-1:0] cnt_r;

  // settle counter, wraps at the end of each row
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable) begin
      if (cnt_r == LAST_V) begin
        cnt_r <= {CW{1'b0}};
      end else begin
        cnt_r <= cnt_r + ONE_V;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last    = (cnt_r == LAST_V);
  assign prelast = (cnt_r == PRE_V);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps a 3-input combinational circuit through all eight rows and checks its
// truth-table signature. Optional feature macro: SWEEPER_STABILITY_CHECK_EN.
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'hCE
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_sweeper_if.slave bus
);

  sweep_state_e state_r;
  logic [2:0]   row_r;
  logic [2:0]   in_vec_r;
  logic         busy_r;
  logic         done_r;
  logic [7:0]   sig_r;
  logic         pass_r;
  logic [3:0]   mm_r;
  logic [2:0]   fail_r;

  logic         clear_s;
  logic         enable_s;
  logic         last_s;
  logic         prelast_s;
  logic         miss_s;
  logic [3:0]   mm_next_s;
  logic         unstable_next_s;
  logic         accept_s;
  logic         abort_busy_s;

  sweep_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear_s),
    .enable  (enable_s),
    .last    (last_s),
    .prelast (prelast_s)
  );

  // timer control and per-row comparison against the expected code
  always_comb begin
    clear_s      = (state_r != APPLY);
    enable_s     = (state_r == APPLY);
    accept_s     = (state_r == IDLE) && bus.start && !bus.abort;
    abort_busy_s = (state_r != IDLE) && bus.abort;
    miss_s       = (bus.dut_out != EXPECTED[sig_bit(row_r)]);
    mm_next_s    = mm_r + {3'b000, miss_s};
  end

`ifdef SWEEPER_STABILITY_CHECK_EN
  logic pre_r;
  logic unstable_r;

  // early sample one cycle before the final capture; any disagreement is sticky
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r      <= 1'b0;
      unstable_r <= 1'b0;
    end else if (accept_s || abort_busy_s) begin
      pre_r      <= 1'b0;
      unstable_r <= 1'b0;
    end else if (state_r == APPLY) begin
      if (prelast_s) begin
        pre_r <= bus.dut_out;
      end else begin
        pre_r <= pre_r;
      end
      unstable_r <= last_s ? unstable_next_s : unstable_r;
    end else begin
      pre_r      <= pre_r;
      unstable_r <= unstable_r;
    end
  end

  // instability including the capture happening this cycle
  always_comb begin
    unstable_next_s = unstable_r | (bus.dut_out != pre_r);
  end

  assign bus.unstable = unstable_r;
`else
  logic stability_unused_s;

  // single capture per row: the early sample point is not used
  always_comb begin
    unstable_next_s    = 1'b0;
    stability_unused_s = prelast_s;
  end

  assign bus.unstable = 1'b0;
`endif

  // sweep FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      row_r    <= 3'd0;
      in_vec_r <= 3'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      sig_r    <= 8'h00;
      pass_r   <= 1'b0;
      mm_r     <= 4'd0;
      fail_r   <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (accept_s) begin
            state_r  <= APPLY;
            busy_r   <= 1'b1;
            row_r    <= 3'd0;
            in_vec_r <= 3'd0;
            sig_r    <= 8'h00;
            pass_r   <= 1'b0;
            mm_r     <= 4'd0;
            fail_r   <= 3'd0;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        APPLY: begin
          if (bus.abort) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            row_r    <= 3'd0;
            in_vec_r <= 3'd0;
            sig_r    <= 8'h00;
            pass_r   <= 1'b0;
            mm_r     <= 4'd0;
            fail_r   <= 3'd0;
          end else if (last_s) begin
            sig_r[sig_bit(row_r)] <= bus.dut_out;
            mm_r                  <= mm_next_s;
            if (miss_s && (mm_r == 4'd0)) begin
              fail_r <= row_r;
            end else begin
              fail_r <= fail_r;
            end
            // row 7 ends the sweep; the row index never wraps back to 0 here
            if (row_r == 3'(ROWS - 1)) begin
              state_r <= DONE;
              done_r  <= 1'b1;
              pass_r  <= (mm_next_s == 4'd0) && !unstable_next_s;
            end else begin
              row_r    <= row_r + 3'd1;
              in_vec_r <= row_r + 3'd1;
            end
          end else begin
            state_r <= APPLY;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          if (bus.abort) begin
            row_r    <= 3'd0;
            in_vec_r <= 3'd0;
            sig_r    <= 8'h00;
            pass_r   <= 1'b0;
            mm_r     <= 4'd0;
            fail_r   <= 3'd0;
          end else begin
            row_r <= row_r;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_vec         = in_vec_r;
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.signature      = sig_r;
  assign bus.pass           = pass_r;
  assign bus.mismatch_count = mm_r;
  assign bus.fail_row       = fail_r;

endmodule
